// File: rtl/ccd_adc_emulator.sv
// Emulates the CCD analog chain plus 16-bit serial ADC, shifting pattern words out MSB-first on adc_sdo.
// Pin edge to registered response is SYNC_STAGES+2 cycles; the timing generator sets the pace.
module ccd_adc_emulator #(
    parameter int          SYNC_STAGES      = 2,
    parameter int          SAMPLES_PER_LINE = 2088,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic        clk_160M,
    input  logic        nrst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] pattern_value,
    input  logic        err_clr,
    input  logic        adc_cs,
    input  logic        adc_sclk,
    output logic        adc_sdo,
    output logic [15:0] sample_word,
    output logic        sample_strobe,
    output logic [11:0] pix_index,
    output logic [15:0] line_cnt,
    output logic        short_read,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   cs_d;
    logic                   sclk_d;
    logic                   cs_rise;
    logic                   cs_fall;
    logic                   sclk_fall;
    logic [15:0]            shreg;
    logic [15:0]            ramp;
    logic [15:0]            lfsr;
    logic [3:0]             bit_cnt;
    logic [15:0]            next_word;
    logic                   lfsr_fb;
    logic                   do_load;

    // Fibonacci taps 16,14,13,11 expressed for a right-shifting register
    always_comb begin
        lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        case (mode)
            2'd0:    next_word = pattern_value;
            2'd1:    next_word = ramp;
            2'd2:    next_word = {4'b0, pix_index};
            default: next_word = lfsr;
        endcase
        do_load = en && cs_rise && (state != CONVERT);
    end

    // Edge pulses are registered so every decision sees one-cycle, glitch-free events
    always_ff @(posedge clk_160M) begin
        if (!nrst) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            cs_d      <= 1'b0;
            sclk_d    <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_rise   <= cs_sync[SYNC_STAGES-1] & ~cs_d;
            cs_fall   <= ~cs_sync[SYNC_STAGES-1] & cs_d;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
        end
    end

    always_ff @(posedge clk_160M) begin
        if (!nrst) begin
            state         <= IDLE;
            adc_sdo       <= 1'b0;
            sample_word   <= '0;
            sample_strobe <= 1'b0;
            pix_index     <= '0;
            line_cnt      <= '0;
            short_read    <= 1'b0;
            overrun       <= 1'b0;
            shreg         <= '0;
            bit_cnt       <= '0;
            ramp          <= '0;
            lfsr          <= LFSR_SEED;
        end else begin
            sample_strobe <= 1'b0;
            if (err_clr) begin
                short_read <= 1'b0;
                overrun    <= 1'b0;
            end
            if (!en) begin
                state   <= IDLE;
                adc_sdo <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        adc_sdo <= 1'b0;
                        if (cs_rise) state <= CONVERT;
                    end
                    CONVERT: begin
                        adc_sdo <= 1'b0;
                        if (cs_fall) begin
                            adc_sdo <= shreg[15];
                            shreg   <= {shreg[14:0], 1'b0};
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (cs_rise) begin
                            short_read <= 1'b1;
                            adc_sdo    <= 1'b0;
                            state      <= CONVERT;
                        end else if (sclk_fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                adc_sdo <= 1'b0;
                                state   <= DONE;
                            end else begin
                                adc_sdo <= shreg[15];
                                shreg   <= {shreg[14:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        adc_sdo <= 1'b0;
                        if (cs_rise) state <= CONVERT;
                        else if (sclk_fall && !cs_d) overrun <= 1'b1;
                    end
                endcase
            end
            if (do_load) begin
                sample_word   <= next_word;
                sample_strobe <= 1'b1;
                shreg         <= next_word;
                if (pix_index == 12'(SAMPLES_PER_LINE - 1)) begin
                    pix_index <= '0;
                    line_cnt  <= line_cnt + 16'd1;
                end else begin
                    pix_index <= pix_index + 12'd1;
                end
                if (mode == 2'd1) ramp <= ramp + 16'd1;
                if (mode == 2'd3) lfsr <= {lfsr_fb, lfsr[15:1]};
            end
        end
    end

endmodule
